mmio_button_queue: RTL

Memory-mapped button-event peripheral for the Sly Man Says processor system. Synchronises and debounces the raw game buttons, converts committed presses into button-index events, and buffers them in a small FIFO. The processor reads events over the data-memory bus at addresses just above the switch/LED I/O words. Its read data joins the `q_dmem` mux alongside switches and RAM, and it pops entries on processor stores.

---
 rtl/mmio_button_queue_if.sv | 32 +++
 rtl/mmio_button_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_button_queue_if.sv
// mmio_button_queue_if
//   Data-memory bus slice shared by the processor and the button-event
//   peripheral.
//   address_dmem : processor data word address
//   wren         : processor store strobe
//   data         : processor store data
//   io_hit       : peripheral claims the current address (DATA or STATUS)
//   q_io         : peripheral read data, 0 when the address is not claimed
//   Modports: master = processor side, slave = peripheral side.
interface mmio_button_queue_if;
  logic [31:0] address_dmem;
  logic        wren;
  logic [31:0] data;
  logic        io_hit;
  logic [31:0] q_io;

  modport master (
    output address_dmem,
    output wren,
    output data,
    input  io_hit,
    input  q_io
  );

  modport slave (
    input  address_dmem,
    input  wren,
    input  data,
    output io_hit,
    output q_io
  );
endinterface

// File: rtl/mmio_button_queue.sv
// mmio_button_queue
//   Memory-mapped button-event peripheral. Raw buttons are synchronised,
//   debounced, turned into press events, arbitrated lowest index first and
//   buffered in a small FIFO that the processor reads over the data bus.
//
//   Ports:
//     clock       : system clock, rising edge
//     reset_n     : asynchronous active-low reset
//     btn_raw     : raw asynchronous button levels, 1 = pressed
//     bus         : data-memory bus slice (slave modport)
//                   DATA   at BASE_ADDR   reads {valid, 26'b0, event[4:0]}
//                   STATUS at BASE_ADDR+1 reads {27'b0, overflow, count[3:0]}
//                   STATUS write: data[0] pop, data[1] clear overflow,
//                   data[2] flush
//     irq_pending : registered, 1 while the FIFO holds at least one event
//
//   Optional feature: define BTN_RELEASE_EVT_EN to also queue release events
//   (event bit 4 = 1). Without it releases generate nothing and bit 4 is 0.
module mmio_button_queue #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [31:0] BASE_ADDR       = 32'd4098
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_BTN-1:0]  btn_raw,
  mmio_button_queue_if.slave  bus,
  output logic                irq_pending
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd1;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] prev_q;
  logic [NUM_BTN-1:0] committed_q;
  logic [NUM_BTN-1:0] committed_d;
  logic [NUM_BTN-1:0] pending_q;
  logic [NUM_BTN-1:0] pending_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

`ifdef BTN_RELEASE_EVT_EN
  logic [NUM_BTN-1:0] relPending_q;
  logic [NUM_BTN-1:0] relPending_d;
`endif

  logic       grantValid;
  logic [3:0] grantIdx;
  logic       grantRel;
  logic [4:0] pushEvent;

  logic [4:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] rdPtr_d;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             irq_q;

  logic       dataHit;
  logic       statusHit;
  logic       popReq;
  logic       clrOvfReq;
  logic       flushReq;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       doPop;
  logic       doPush;
  logic       ovfSet;
  logic [4:0] headEvent;
  logic       unusedDataBits;

  // Synchroniser plus one extra stage holding the previous synced level
  // that the debounce counters compare against.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Debounce: any change restarts the count; the level is committed once the
  // count has saturated at DEBOUNCE_CYCLES-1 with the input still stable.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i]       = cnt_q[i];
      committed_d[i] = committed_q[i];
      if (sync2_q[i] != prev_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        committed_d[i] = sync2_q[i];
      end
    end
  end

  // Arbiter: the lowest-index press is served first; release bits only get
  // a turn when no press is waiting. New edges are merged after clearing so
  // a fresh edge on the granted button is not lost.
  always_comb begin
    pending_d  = pending_q;
    grantValid = 1'b0;
    grantIdx   = '0;
    grantRel   = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!grantValid && pending_q[i]) begin
        grantValid   = 1'b1;
        grantIdx     = 4'(i);
        pending_d[i] = 1'b0;
      end
    end
`ifdef BTN_RELEASE_EVT_EN
    relPending_d = relPending_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!grantValid && relPending_q[i]) begin
        grantValid      = 1'b1;
        grantIdx        = 4'(i);
        grantRel        = 1'b1;
        relPending_d[i] = 1'b0;
      end
    end
    relPending_d = relPending_d | (committed_q & ~committed_d);
`endif
    pending_d = pending_d | (committed_d & ~committed_q);
  end

  assign pushEvent = {grantRel, grantIdx};

  assign dataHit   = (bus.address_dmem == BASE_ADDR);
  assign statusHit = (bus.address_dmem == STATUS_ADDR);
  assign bus.io_hit = dataHit | statusHit;

  assign popReq    = bus.wren & statusHit & bus.data[0];
  assign clrOvfReq = bus.wren & statusHit & bus.data[1];
  assign flushReq  = bus.wren & statusHit & bus.data[2];
  assign unusedDataBits = ^bus.data[31:3];

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == DEPTH_CNT);

  // A flush overrides everything in the same cycle; a pop on a full FIFO
  // frees the slot the simultaneous push needs, so no overflow is raised.
  assign doPop  = popReq & ~fifoEmpty & ~flushReq;
  assign doPush = grantValid & ~flushReq & (~fifoFull | doPop);
  assign ovfSet = grantValid & ~flushReq & fifoFull & ~doPop;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flushReq) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      if (doPush && !doPop) begin
        count_d = count_q + 1'b1;
      end else if (doPop && !doPush) begin
        count_d = count_q - 1'b1;
      end
    end
    if (clrOvfReq) begin
      overflow_d = 1'b0;
    end
    if (ovfSet) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      committed_q <= '0;
      pending_q   <= '0;
`ifdef BTN_RELEASE_EVT_EN
      relPending_q <= '0;
`endif
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      committed_q <= committed_d;
      pending_q   <= pending_d;
`ifdef BTN_RELEASE_EVT_EN
      relPending_q <= relPending_d;
`endif
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= (count_d != '0);
    end
  end

  // Storage needs no reset: entries are only visible through count/rdPtr.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushEvent;
    end
  end

  assign headEvent   = fifoEmpty ? 5'd0 : mem_q[rdPtr_q];
  assign irq_pending = irq_q;

  always_comb begin
    bus.q_io = '0;
    if (dataHit) begin
      bus.q_io = {~fifoEmpty, 26'b0, headEvent};
    end else if (statusHit) begin
      bus.q_io = {27'b0, overflow_q, 4'(count_q)};
    end
  end

endmodule
